// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: owners, FSM states and the full byte mask.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic [7:0] FULL_MASK = 8'hFF;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Winner selector between fetch and data requests.
// MEM_ARB_RR_EN: ties go to the requester not granted last; otherwise data always wins.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic   sys_clk,
    input  logic   sys_rst,
    input  logic   take_i,
`endif
    input  logic   if_req_i,
    input  logic   d_req_i,
    output owner_e win_o
);

`ifdef MEM_ARB_RR_EN
    owner_e last_q;

    always_comb begin
        win_o = OWN_NONE;
        if (d_req_i && if_req_i) begin
            win_o = (last_q == OWN_DATA) ? OWN_FETCH : OWN_DATA;
        end else if (d_req_i) begin
            win_o = OWN_DATA;
        end else if (if_req_i) begin
            win_o = OWN_FETCH;
        end
    end

    // Remembers every grant, not only ties, so alternation follows real history.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            last_q <= OWN_NONE;
        end else if (take_i) begin
            last_q <= win_o;
        end
    end
`else
    always_comb begin
        win_o = OWN_NONE;
        if (d_req_i) begin
            win_o = OWN_DATA;
        end else if (if_req_i) begin
            win_o = OWN_FETCH;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; one transaction in flight.
// Build option MEM_ARB_RR_EN enables round-robin tie-break (default: fixed data-over-fetch).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [31:0]     if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [7:0]      d_wmask,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            err
);

    // state    | meaning
    // ST_IDLE  | nothing in flight; pick a winner, pulse its gnt, latch its fields
    // ST_ISSUE | mem_req held with latched fields until mem_ready
    // ST_WAIT  | waiting for mem_rvalid, counting toward TIMEOUT

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    owner_e          pick_win;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [7:0]      wmask_q, wmask_d;
    logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic            err_q, err_d;
    logic            if_rvalid_q, if_rvalid_d;
    logic [31:0]     if_rdata_q, if_rdata_d;
    logic            d_rvalid_q, d_rvalid_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;
    logic            if_gnt_c, d_gnt_c;
    logic            deliver;
    logic            timed_out;

`ifdef MEM_ARB_RR_EN
    mem_arb_pick u_pick (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .take_i   ((state_q == ST_IDLE) && (if_req || d_req)),
        .if_req_i (if_req),
        .d_req_i  (d_req),
        .win_o    (pick_win)
    );
`else
    mem_arb_pick u_pick (
        .if_req_i (if_req),
        .d_req_i  (d_req),
        .win_o    (pick_win)
    );
`endif

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = '0;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = '0;
        if_gnt_c    = 1'b0;
        d_gnt_c     = 1'b0;
        deliver     = 1'b0;
        timed_out   = 1'b0;
        cnt_inc     = cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (pick_win == OWN_DATA) begin
                    d_gnt_c = 1'b1;
                    owner_d = OWN_DATA;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    wmask_d = d_wmask;
                    state_d = ST_ISSUE;
                end else if (pick_win == OWN_FETCH) begin
                    if_gnt_c = 1'b1;
                    owner_d  = OWN_FETCH;
                    we_d     = 1'b0;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    wmask_d  = FULL_MASK;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                // A response landing on the terminal cycle still counts as a real response.
                if (mem_rvalid) begin
                    deliver = 1'b1;
                end else if ((TIMEOUT != 0) && (cnt_inc == TO_W'(TIMEOUT))) begin
                    deliver   = 1'b1;
                    timed_out = 1'b1;
                    err_d     = 1'b1;
                end
                if (deliver) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                    if (owner_q == OWN_FETCH) begin
                        if_rvalid_d = 1'b1;
                        if (!timed_out) begin
                            if_rdata_d = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                        end
                    end else if (owner_q == OWN_DATA) begin
                        d_rvalid_d = 1'b1;
                        if (!timed_out && !we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // gnt is combinational from req, so it must be masked while reset is held.
    assign if_gnt    = if_gnt_c & sys_rst;
    assign d_gnt     = d_gnt_c & sys_rst;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = (state_q == ST_ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int XLEN    = 64;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 8;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic            sys_clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic            if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [XLEN-1:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [7:0]      d_wmask = '0;
    logic            mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic            if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, err;
    logic [31:0]     if_rdata;
    logic [XLEN-1:0] d_rdata, mem_addr, mem_wdata;
    logic [7:0]      mem_wmask;

    always #5 sys_clk = ~sys_clk;

    mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: 0 none, 1 fetch, 2 data
    bit m_err;
    int m_last;

    // transaction descriptor
    bit              t_if, t_d, t_we;
    logic [XLEN-1:0] t_if_addr, t_d_addr, t_wdata, t_rdata;
    logic [7:0]      t_wmask;
    int              t_stall, t_rv;

    // observed
    int              o_gnt_cyc, o_first_issue, o_issue_n, o_rv_cyc;
    logic [1:0]      o_gnt_who, o_rv_who;
    bit              o_stable;
    logic [XLEN-1:0] o_addr, o_wdata, o_rdata;
    logic            o_we, o_err;
    logic [7:0]      o_wmask;

    // expected
    logic [1:0]      e_who;
    int              e_rv_cyc, e_issue_n;
    logic [XLEN-1:0] e_addr, e_rdata;
    logic            e_we;
    logic [7:0]      e_wmask;

    function automatic void model_txn();
        int win;
        int wait_start;
        if (t_d && t_if) win = (RR_EN && m_last == 2) ? 1 : 2;
        else if (t_d)    win = 2;
        else             win = 1;
        m_last     = win;
        e_who      = (win == 2) ? 2'b10 : 2'b01;
        e_addr     = (win == 2) ? t_d_addr : t_if_addr;
        e_we       = (win == 2) ? t_we : 1'b0;
        e_wmask    = (win == 2) ? t_wmask : 8'hFF;
        e_issue_n  = t_stall + 1;
        wait_start = 2 + t_stall;
        if (t_rv >= 0 && t_rv < TIMEOUT) begin
            e_rv_cyc = wait_start + t_rv + 1;
            if (win == 1)  e_rdata = t_if_addr[2] ? {32'h0, t_rdata[63:32]} : {32'h0, t_rdata[31:0]};
            else if (t_we) e_rdata = '0;
            else           e_rdata = t_rdata;
        end else begin
            e_rv_cyc = wait_start + TIMEOUT;
            e_rdata  = '0;
            m_err    = 1'b1;
        end
    endfunction

    task automatic do_txn();
        bit in_wait = 1'b0;
        bit granted = 1'b0;
        int wait_idx = 0;
        o_gnt_cyc = -1; o_first_issue = -1; o_issue_n = 0; o_rv_cyc = -1;
        o_gnt_who = 2'b00; o_rv_who = 2'b00; o_stable = 1'b1;
        o_rdata = '0; o_err = 1'b0; o_addr = '0; o_wdata = '0; o_we = 1'b0; o_wmask = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge sys_clk); #1;
            if_req = t_if && !granted; d_req = t_d && !granted;
            if_addr = t_if_addr; d_addr = t_d_addr; d_we = t_we; d_wdata = t_wdata; d_wmask = t_wmask;
            mem_ready  = mem_req && (o_issue_n >= t_stall);
            mem_rvalid = in_wait && (t_rv >= 0) && (wait_idx == t_rv);
            mem_rdata  = t_rdata;
            @(negedge sys_clk);
            if (if_gnt || d_gnt) begin
                if (!granted) o_gnt_cyc = cyc;
                o_gnt_who = o_gnt_who | {d_gnt, if_gnt};
                granted = 1'b1;
            end
            if (mem_req) begin
                if (o_issue_n == 0) begin
                    o_first_issue = cyc; o_addr = mem_addr; o_we = mem_we; o_wdata = mem_wdata; o_wmask = mem_wmask;
                end else if (mem_addr !== o_addr || mem_we !== o_we || mem_wdata !== o_wdata || mem_wmask !== o_wmask) begin
                    o_stable = 1'b0;
                end
                o_issue_n++;
            end
            if (in_wait) wait_idx++;
            if (mem_req && mem_ready) begin in_wait = 1'b1; wait_idx = 0; end
            if (if_rvalid || d_rvalid) begin
                o_rv_cyc = cyc; o_rv_who = {d_rvalid, if_rvalid};
                o_rdata  = d_rvalid ? d_rdata : {32'h0, if_rdata};
                o_err    = err;
                break;
            end
        end
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        sys_rst = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        m_err = 1'b0; m_last = 0;
    endtask

    task automatic test_reset();
        #2 sys_rst = 1'b0;
        if_req = 1'b1; d_req = 1'b1; mem_rvalid = 1'b1; mem_ready = 1'b1;
        @(posedge sys_clk); #1;
        n_tests++;
        if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, err} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: gnt=%b/%b mem_req=%b err=%b expected all zero", if_gnt, d_gnt, mem_req, err);
        end
        @(negedge sys_clk);
        if_req = 1'b0; d_req = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b0;
        sys_rst = 1'b1; m_err = 1'b0; m_last = 0;
        @(negedge sys_clk);
        n_tests++;
        if (mem_req !== 1'b0 || err !== 1'b0 || if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: mem_req=%b err=%b rvalid=%b%b expected 0", mem_req, err, if_rvalid, d_rvalid);
        end
    endtask

    task automatic test_fetch_only();
        t_if = 1; t_d = 0; t_we = 0; t_if_addr = 64'h8000_0004; t_d_addr = '0; t_wdata = '0; t_wmask = '0;
        t_rdata = 64'h1111_2222_3333_4444; t_stall = 0; t_rv = 0;
        model_txn();
        do_txn();
        n_tests++; if (o_gnt_cyc !== 0 || o_gnt_who !== 2'b01) begin n_fail++; $display("FAIL fetch_gnt: cyc=%0d who=%b expected 0/01", o_gnt_cyc, o_gnt_who); end
        n_tests++; if (o_first_issue !== 1 || o_addr !== 64'h8000_0004) begin n_fail++; $display("FAIL fetch_issue: cyc=%0d addr=%h expected 1/80000004", o_first_issue, o_addr); end
        n_tests++; if (o_we !== 1'b0 || o_wmask !== 8'hFF) begin n_fail++; $display("FAIL fetch_fields: we=%b mask=%h expected 0/ff", o_we, o_wmask); end
        n_tests++; if (o_rv_cyc !== 3 || o_rv_who !== 2'b01) begin n_fail++; $display("FAIL fetch_rvalid: cyc=%0d who=%b expected 3/01", o_rv_cyc, o_rv_who); end
        n_tests++; if (o_rdata !== 64'h1111_2222) begin n_fail++; $display("FAIL fetch_rdata: got %h expected 11112222", o_rdata); end
    endtask

    task automatic test_store_stall();
        t_if = 0; t_d = 1; t_we = 1; t_d_addr = 64'h8000_1000; t_wdata = 64'hDEAD_BEEF; t_wmask = 8'h0F;
        t_rdata = 64'hFFFF_FFFF_FFFF_FFFF; t_stall = 3; t_rv = 0;
        model_txn();
        do_txn();
        n_tests++; if (o_issue_n !== 4 || o_stable !== 1'b1) begin n_fail++; $display("FAIL store_issue: cycles=%0d stable=%b expected 4/1", o_issue_n, o_stable); end
        n_tests++;
        if (o_addr !== 64'h8000_1000 || o_we !== 1'b1 || o_wdata !== 64'hDEAD_BEEF || o_wmask !== 8'h0F) begin
            n_fail++; $display("FAIL store_fields: addr=%h we=%b wdata=%h mask=%h", o_addr, o_we, o_wdata, o_wmask);
        end
        n_tests++; if (o_rv_cyc !== 6 || o_rv_who !== 2'b10 || o_rdata !== '0) begin n_fail++; $display("FAIL store_ack: cyc=%0d who=%b data=%h expected 6/10/0", o_rv_cyc, o_rv_who, o_rdata); end
    endtask

    task automatic test_tie();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            t_if = 1; t_d = 1; t_we = 0; t_if_addr = 64'h100; t_d_addr = 64'h200; t_wdata = '0; t_wmask = 8'hFF;
            t_rdata = 64'h0123_4567_89AB_CDEF; t_stall = 0; t_rv = 1;
            model_txn();
            do_txn();
            n_tests++;
            if (o_gnt_who !== e_who || o_rv_who !== e_who) begin
                n_fail++; $display("FAIL tie_%0d: gnt=%b rvalid=%b expected %b", k, o_gnt_who, o_rv_who, e_who);
            end
        end
    endtask

    task automatic test_timeout();
        t_if = 0; t_d = 1; t_we = 0; t_d_addr = 64'h300; t_wdata = '0; t_wmask = 8'hFF;
        t_rdata = 64'hAAAA_BBBB_CCCC_DDDD; t_stall = 0; t_rv = -1;
        model_txn();
        do_txn();
        n_tests++; if (o_rv_cyc !== 6 || o_rv_who !== 2'b10) begin n_fail++; $display("FAIL timeout_pulse: cyc=%0d who=%b expected 6/10", o_rv_cyc, o_rv_who); end
        n_tests++; if (o_rdata !== '0 || o_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: data=%h err=%b expected 0/1", o_rdata, o_err); end
        t_if = 1; t_d = 0; t_if_addr = 64'h8000_0010; t_rdata = 64'h5555_6666_7777_8888; t_rv = 0;
        model_txn();
        do_txn();
        n_tests++;
        if (o_rv_cyc !== 3 || o_rdata !== 64'h7777_8888 || o_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_next: cyc=%0d data=%h err=%b expected 3/77778888/1", o_rv_cyc, o_rdata, o_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(posedge sys_clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8000_2000; d_wmask = 8'hFF; mem_rdata = 64'hABCD;
        @(negedge sys_clk);
        n_tests++; if (d_gnt !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL rstwait_pre: gnt=%b err=%b expected 1/1", d_gnt, err); end
        @(posedge sys_clk); #1; d_req = 1'b0; mem_ready = 1'b1;
        @(negedge sys_clk);
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstwait_issue: mem_req=%b expected 1", mem_req); end
        @(posedge sys_clk); #1; mem_ready = 1'b0;
        d_req = 1'b1; sys_rst = 1'b0; #1;
        n_tests++;
        if ({err, mem_req, d_gnt, if_gnt, d_rvalid, if_rvalid, mem_addr, mem_wmask} !== '0) begin
            n_fail++; $display("FAIL rstwait_async: err=%b mem_req=%b gnt=%b addr=%h expected all zero", err, mem_req, d_gnt, mem_addr);
        end
        m_err = 1'b0; m_last = 0;
        @(negedge sys_clk); sys_rst = 1'b1; d_req = 1'b0;
        @(posedge sys_clk); #1; mem_rvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            n_tests++;
            if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++; $display("FAIL rstwait_late_%0d: rvalid=%b%b mem_req=%b expected 0", k, d_rvalid, if_rvalid, mem_req);
            end
            @(posedge sys_clk); #1; mem_rvalid = 1'b0;
        end
    endtask

    task automatic test_spurious();
        @(negedge sys_clk); mem_rvalid = 1'b1; mem_rdata = 64'h1234;
        @(negedge sys_clk); mem_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++; $display("FAIL spurious_%0d: rvalid=%b%b mem_req=%b expected 0", k, d_rvalid, if_rvalid, mem_req);
            end
            @(negedge sys_clk);
        end
        t_if = 1; t_d = 0; t_we = 0; t_if_addr = 64'h8000_0008; t_rdata = 64'h9999_AAAA_BBBB_CCCC; t_stall = 1; t_rv = 2;
        model_txn();
        do_txn();
        n_tests++;
        if (o_gnt_cyc !== 0 || o_rv_cyc !== e_rv_cyc || o_rdata !== 64'hBBBB_CCCC) begin
            n_fail++; $display("FAIL spurious_after: gnt=%0d rv=%0d data=%h expected 0/%0d/bbbbcccc", o_gnt_cyc, o_rv_cyc, o_rdata, e_rv_cyc);
        end
    endtask

    task automatic test_random();
        int r;
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(1, 3);
            t_if = r[0]; t_d = r[1]; t_we = $urandom_range(0, 1);
            t_if_addr = {$urandom, $urandom}; t_d_addr = {$urandom, $urandom};
            t_wdata = {$urandom, $urandom}; t_wmask = 8'($urandom); t_rdata = {$urandom, $urandom};
            t_stall = $urandom_range(0, 3);
            r = $urandom_range(0, 7);
            t_rv = (r == 0) ? -1 : (r % 3);
            model_txn();
            do_txn();
            n_tests++;
            if (o_gnt_cyc !== 0 || o_gnt_who !== e_who || o_first_issue !== 1 || o_issue_n !== e_issue_n || o_stable !== 1'b1) begin
                n_fail++; $display("FAIL rand_%0d_issue: gnt=%0d/%b issue=%0d/%0d stable=%b expected 0/%b 1/%0d 1",
                    k, o_gnt_cyc, o_gnt_who, o_first_issue, o_issue_n, o_stable, e_who, e_issue_n);
            end
            n_tests++;
            if (o_addr !== e_addr || o_we !== e_we || o_wmask !== e_wmask || (e_who == 2'b10 && o_wdata !== t_wdata)) begin
                n_fail++; $display("FAIL rand_%0d_fields: addr=%h we=%b mask=%h expected %h/%b/%h", k, o_addr, o_we, o_wmask, e_addr, e_we, e_wmask);
            end
            n_tests++;
            if (o_rv_cyc !== e_rv_cyc || o_rv_who !== e_who || o_rdata !== e_rdata || o_err !== m_err) begin
                n_fail++; $display("FAIL rand_%0d_resp: cyc=%0d who=%b data=%h err=%b expected %0d/%b/%h/%b",
                    k, o_rv_cyc, o_rv_who, o_rdata, o_err, e_rv_cyc, e_who, e_rdata, m_err);
            end
        end
    endtask

    initial begin
        m_err = 1'b0; m_last = 0;
        test_reset();
        test_fetch_only();
        test_store_stall();
        test_tie();
        test_timeout();
        test_reset_mid_wait();
        test_spurious();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
